// File: rtl/lc_event_recorder.sv
// Local-coincidence burst recorder: one record per contiguous burst, buffered in a FWFT FIFO.
// Optional macro LC_EVENT_PEAK_EN adds a per-record peak-popcount field (rec_peak).
module lc_event_recorder #(
    parameter int N_CHANNELS      = 24,
    parameter int TS_WIDTH        = 48,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic [TS_WIDTH-1:0]        timestamp,
    input  logic [N_CHANNELS-1:0]      local_coinc,
    input  logic [15:0]                max_event_len,
    output logic                       rec_valid,
    input  logic                       rec_ready,
    output logic [TS_WIDTH-1:0]        rec_ts,
    output logic [N_CHANNELS-1:0]      rec_mask,
    output logic [15:0]                rec_len,
    output logic                       rec_trunc,
`ifdef LC_EVENT_PEAK_EN
    output logic [7:0]                 rec_peak,
`endif
    output logic [FIFO_DEPTH_LOG2:0]   fifo_count,
    output logic [15:0]                overflow_count,
    output logic                       busy,
    output logic [1:0]                 dbg_state
);

    localparam int DEPTH     = 1 << FIFO_DEPTH_LOG2;
    localparam int MASK_LO   = TS_WIDTH;
    localparam int LEN_LO    = TS_WIDTH + N_CHANNELS;
    localparam int TRUNC_BIT = LEN_LO + 16;
`ifdef LC_EVENT_PEAK_EN
    localparam int PEAK_LO   = TRUNC_BIT + 1;
    localparam int REC_W     = TS_WIDTH + N_CHANNELS + 17 + 8;
`else
    localparam int REC_W     = TS_WIDTH + N_CHANNELS + 17;
`endif

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_OPEN    = 2'd1,
        S_HOLDOFF = 2'd2
    } state_t;

    state_t                    r_state;
    logic [TS_WIDTH-1:0]       r_ts;
    logic [N_CHANNELS-1:0]     r_mask;
    logic [15:0]               r_len;

    logic                      w_any;
    logic [15:0]               w_lim;
    logic [15:0]               w_len_inc;
    logic                      w_push;
    logic [TS_WIDTH-1:0]       w_rec_ts;
    logic [N_CHANNELS-1:0]     w_rec_mask;
    logic [15:0]               w_rec_len;
    logic                      w_rec_trunc;
    logic [REC_W-1:0]          w_wdata;

`ifdef LC_EVENT_PEAK_EN
    logic [7:0]                r_peak;
    logic [7:0]                w_pc;
    logic [7:0]                w_peak_max;
    logic [7:0]                w_rec_peak;

    function automatic logic [7:0] popcount(input logic [N_CHANNELS-1:0] v);
        logic [7:0] c;
        c = 8'd0;
        for (int i = 0; i < N_CHANNELS; i++) c = c + {7'd0, v[i]};
        return c;
    endfunction

    assign w_pc       = popcount(local_coinc);
    assign w_peak_max = (w_pc > r_peak) ? w_pc : r_peak;
`endif

    assign w_any     = |local_coinc;
    assign w_lim     = (max_event_len == 16'd0) ? 16'hFFFF : max_event_len;
    assign w_len_inc = r_len + 16'd1;

    // Record contents as they stand on the edge that closes the event.
    always_comb begin
        w_push      = 1'b0;
        w_rec_ts    = r_ts;
        w_rec_mask  = r_mask;
        w_rec_len   = r_len;
        w_rec_trunc = 1'b0;
`ifdef LC_EVENT_PEAK_EN
        w_rec_peak  = r_peak;
`endif
        case (r_state)
            S_IDLE: begin
                if (enable && w_any && w_lim == 16'd1) begin
                    w_push      = 1'b1;
                    w_rec_ts    = timestamp;
                    w_rec_mask  = local_coinc;
                    w_rec_len   = 16'd1;
                    w_rec_trunc = 1'b1;
`ifdef LC_EVENT_PEAK_EN
                    w_rec_peak  = w_pc;
`endif
                end
            end
            S_OPEN: begin
                if (w_any) begin
                    if (w_len_inc == w_lim) begin
                        w_push      = 1'b1;
                        w_rec_mask  = r_mask | local_coinc;
                        w_rec_len   = w_len_inc;
                        w_rec_trunc = 1'b1;
`ifdef LC_EVENT_PEAK_EN
                        w_rec_peak  = w_peak_max;
`endif
                    end
                end else begin
                    w_push = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_ts    <= '0;
            r_mask  <= '0;
            r_len   <= 16'd0;
`ifdef LC_EVENT_PEAK_EN
            r_peak  <= 8'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable && w_any) begin
                        r_ts    <= timestamp;
                        r_mask  <= local_coinc;
                        r_len   <= 16'd1;
`ifdef LC_EVENT_PEAK_EN
                        r_peak  <= w_pc;
`endif
                        r_state <= (w_lim == 16'd1) ? S_HOLDOFF : S_OPEN;
                    end
                end
                S_OPEN: begin
                    if (w_any) begin
                        r_mask <= r_mask | local_coinc;
                        r_len  <= w_len_inc;
`ifdef LC_EVENT_PEAK_EN
                        r_peak <= w_peak_max;
`endif
                        if (w_len_inc == w_lim) r_state <= S_HOLDOFF;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_HOLDOFF: begin
                    if (!w_any) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign dbg_state = r_state;

    // FIFO: a push into a full FIFO survives only if the head leaves on the same edge.
    logic [REC_W-1:0]           r_mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] r_rd_ptr;
    logic [FIFO_DEPTH_LOG2:0]   r_count;
    logic [15:0]                r_overflow;
    logic                       w_full;
    logic                       w_pop;
    logic                       w_wr;
    logic                       w_drop;
    logic [REC_W-1:0]           w_head;

    assign w_full = (r_count == (FIFO_DEPTH_LOG2+1)'(DEPTH));
    assign w_pop  = (r_count != '0) && rec_ready;
    assign w_wr   = w_push && (!w_full || w_pop);
    assign w_drop = w_push && w_full && !w_pop;

    always_comb begin
        w_wdata = '0;
        w_wdata[0 +: TS_WIDTH]         = w_rec_ts;
        w_wdata[MASK_LO +: N_CHANNELS] = w_rec_mask;
        w_wdata[LEN_LO +: 16]          = w_rec_len;
        w_wdata[TRUNC_BIT]             = w_rec_trunc;
`ifdef LC_EVENT_PEAK_EN
        w_wdata[PEAK_LO +: 8]          = w_rec_peak;
`endif
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= w_wdata;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 16'd0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_wr && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_wr && w_pop) r_count <= r_count - 1'b1;
            if (w_drop && r_overflow != 16'hFFFF) r_overflow <= r_overflow + 16'd1;
        end
    end

    assign w_head         = r_mem[r_rd_ptr];
    assign rec_valid      = (r_count != '0);
    assign fifo_count     = r_count;
    assign overflow_count = r_overflow;

    // Outputs read zero while empty so stale memory never shows after reset.
    always_comb begin
        rec_ts    = rec_valid ? w_head[0 +: TS_WIDTH] : '0;
        rec_mask  = rec_valid ? w_head[MASK_LO +: N_CHANNELS] : '0;
        rec_len   = rec_valid ? w_head[LEN_LO +: 16] : 16'd0;
        rec_trunc = rec_valid ? w_head[TRUNC_BIT] : 1'b0;
`ifdef LC_EVENT_PEAK_EN
        rec_peak  = rec_valid ? w_head[PEAK_LO +: 8] : 8'd0;
`endif
    end

endmodule

// File: tb/tb_lc_event_recorder.sv
// Bench for lc_event_recorder: table of bursts plus hand sequences; records are
// checked against an expected queue as they leave the FIFO.
module tb_lc_event_recorder;

    typedef struct packed {
        logic [47:0] ts;
        logic [23:0] mask;
        logic [15:0] len;
        logic        trunc;
        logic [7:0]  peak;
    } exp_rec_t;

    typedef struct {
        logic [3:0][23:0] pat;
        int               n;
        logic [15:0]      maxlen;
        logic [23:0]      mask;
        logic [15:0]      len;
        logic             trunc;
        logic [7:0]       peak;
    } burst_vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [47:0] timestamp;
    logic [23:0] local_coinc;
    logic [15:0] max_event_len;
    logic        rec_valid;
    logic        rec_ready;
    logic [47:0] rec_ts;
    logic [23:0] rec_mask;
    logic [15:0] rec_len;
    logic        rec_trunc;
    logic [7:0]  rec_peak;
    logic [2:0]  fifo_count;
    logic [15:0] overflow_count;
    logic        busy;
    logic [1:0]  dbg_state;

    exp_rec_t    exp_q[$];
    exp_rec_t    mon_e;
    exp_rec_t    e;
    burst_vec_t  vecs[8];
    int          total = 0;
    int          bad = 0;

    lc_event_recorder #(
        .N_CHANNELS(24),
        .TS_WIDTH(48),
        .FIFO_DEPTH_LOG2(2)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .enable(enable),
        .timestamp(timestamp),
        .local_coinc(local_coinc),
        .max_event_len(max_event_len),
        .rec_valid(rec_valid),
        .rec_ready(rec_ready),
        .rec_ts(rec_ts),
        .rec_mask(rec_mask),
        .rec_len(rec_len),
        .rec_trunc(rec_trunc),
`ifdef LC_EVENT_PEAK_EN
        .rec_peak(rec_peak),
`endif
        .fifo_count(fifo_count),
        .overflow_count(overflow_count),
        .busy(busy),
        .dbg_state(dbg_state)
    );

`ifndef LC_EVENT_PEAK_EN
    assign rec_peak = 8'd0;
`endif

    // Clock and reset
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Driver tasks: inputs change 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
        timestamp = timestamp + 48'd1;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
        chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("drain_fifo_count", 64'(fifo_count), 64'd0);
    endtask

    task automatic single_burst(input logic [23:0] lc, input logic push_exp);
        exp_rec_t r;
        r = '{ts: timestamp, mask: lc, len: 16'd1, trunc: 1'b0, peak: 8'd1};
        if (push_exp) exp_q.push_back(r);
        local_coinc = lc;
        tick();
        local_coinc = 24'd0;
        tick();
        tick();
    endtask

    task automatic set_vec(input int k, input logic [23:0] p0, input logic [23:0] p1,
                           input logic [23:0] p2, input logic [23:0] p3, input int n,
                           input logic [15:0] ml, input logic [23:0] m, input logic [15:0] l,
                           input logic t, input logic [7:0] pk);
        vecs[k].pat[0] = p0;
        vecs[k].pat[1] = p1;
        vecs[k].pat[2] = p2;
        vecs[k].pat[3] = p3;
        vecs[k].n      = n;
        vecs[k].maxlen = ml;
        vecs[k].mask   = m;
        vecs[k].len    = l;
        vecs[k].trunc  = t;
        vecs[k].peak   = pk;
    endtask

    // Scoreboard: compare the head whenever it is accepted on the coming edge.
    always @(negedge clk) begin
        if (reset_n && rec_valid && rec_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_record: got ts=%0h mask=%0h len=%0d want=none",
                         rec_ts, rec_mask, rec_len);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rec_ts", 64'(rec_ts), 64'(mon_e.ts));
                chk("rec_mask", 64'(rec_mask), 64'(mon_e.mask));
                chk("rec_len", 64'(rec_len), 64'(mon_e.len));
                chk("rec_trunc", 64'(rec_trunc), 64'(mon_e.trunc));
`ifdef LC_EVENT_PEAK_EN
                chk("rec_peak", 64'(rec_peak), 64'(mon_e.peak));
`endif
            end
        end
    end

    initial begin
        set_vec(0, 24'h000003, 24'h000003, 24'h000003, 24'h000003, 3, 16'd0, 24'h000003, 16'd3, 1'b0, 8'd2);
        set_vec(1, 24'h000001, 24'h000010, 24'h000100, 24'h000100, 3, 16'd0, 24'h000111, 16'd3, 1'b0, 8'd1);
        set_vec(2, 24'h000007, 24'h000003, 24'h000003, 24'h000003, 2, 16'd0, 24'h000007, 16'd2, 1'b0, 8'd3);
        set_vec(3, 24'h800000, 24'h800000, 24'h800000, 24'h800000, 10, 16'd4, 24'h800000, 16'd4, 1'b1, 8'd1);
        set_vec(4, 24'hFFFFFF, 24'h000001, 24'h000001, 24'h000001, 2, 16'd1, 24'hFFFFFF, 16'd1, 1'b1, 8'd24);
        set_vec(5, 24'h000005, 24'h00000A, 24'h000001, 24'h000001, 3, 16'd2, 24'h00000F, 16'd2, 1'b1, 8'd2);
        set_vec(6, 24'h000001, 24'h000002, 24'h000004, 24'h000004, 3, 16'd3, 24'h000007, 16'd3, 1'b1, 8'd1);
        set_vec(7, 24'h000001, 24'h000002, 24'h000004, 24'h000004, 3, 16'd4, 24'h000007, 16'd3, 1'b0, 8'd1);

        reset_n       = 1'b0;
        enable        = 1'b1;
        timestamp     = 48'd0;
        local_coinc   = 24'd0;
        max_event_len = 16'd0;
        rec_ready     = 1'b0;
        tick();
        tick();
        chk("reset_valid", 64'(rec_valid), 64'd0);
        chk("reset_fifo_count", 64'(fifo_count), 64'd0);
        chk("reset_overflow", 64'(overflow_count), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_rec_fields", 64'({rec_ts, rec_len}), 64'd0);
        chk("reset_rec_mask", 64'({rec_mask, rec_trunc, rec_peak}), 64'd0);
        reset_n = 1'b1;
        tick();

        // Single burst with the closing-edge latency checked cycle by cycle.
        timestamp = 48'd100;
        exp_q.push_back('{ts: 48'd100, mask: 24'h3, len: 16'd3, trunc: 1'b0, peak: 8'd2});
        for (int i = 0; i < 3; i++) begin
            local_coinc = 24'h000003;
            tick();
        end
        local_coinc = 24'd0;
        chk("valid_before_close", 64'(rec_valid), 64'd0);
        tick();
        chk("valid_after_close", 64'(rec_valid), 64'd1);
        chk("count_after_close", 64'(fifo_count), 64'd1);
        chk("head_ts", 64'(rec_ts), 64'd100);
        chk("head_mask", 64'(rec_mask), 64'h3);
        chk("head_len", 64'(rec_len), 64'd3);
        chk("head_trunc", 64'(rec_trunc), 64'd0);
        tick();
        tick();
        chk("hold_ts", 64'(rec_ts), 64'd100);
        chk("hold_len", 64'(rec_len), 64'd3);
        rec_ready = 1'b1;
        drain();
        tick();
        chk("ready_when_empty", 64'(fifo_count), 64'd0);

        // Table of bursts with the consumer always ready.
        for (int v = 0; v < 8; v++) begin
            max_event_len = vecs[v].maxlen;
            e = '{ts: timestamp, mask: vecs[v].mask, len: vecs[v].len,
                  trunc: vecs[v].trunc, peak: vecs[v].peak};
            exp_q.push_back(e);
            for (int i = 0; i < vecs[v].n; i++) begin
                local_coinc = vecs[v].pat[(i > 3) ? 3 : i];
                tick();
            end
            local_coinc = 24'd0;
            tick();
            tick();
            drain();
            chk("table_busy_idle", 64'(busy), 64'd0);
        end
        max_event_len = 16'd0;

        // Overflow: six bursts into a four-entry FIFO, consumer stalled.
        rec_ready = 1'b0;
        for (int k = 0; k < 6; k++) single_burst(24'h000001 << k, k < 4);
        chk("ovf_fifo_count", 64'(fifo_count), 64'd4);
        chk("ovf_overflow_count", 64'(overflow_count), 64'd2);

        // Full FIFO: closing edge coincides with a pop.
        exp_q.push_back('{ts: timestamp, mask: 24'h000040, len: 16'd1, trunc: 1'b0, peak: 8'd1});
        local_coinc = 24'h000040;
        tick();
        local_coinc = 24'd0;
        rec_ready = 1'b1;
        tick();
        rec_ready = 1'b0;
        chk("simpop_fifo_count", 64'(fifo_count), 64'd4);
        chk("simpop_overflow", 64'(overflow_count), 64'd2);
        rec_ready = 1'b1;
        drain();
        chk("post_drain_overflow", 64'(overflow_count), 64'd2);

        // Reset with two queued records and an event open.
        rec_ready = 1'b0;
        single_burst(24'h000011, 1'b0);
        single_burst(24'h000022, 1'b0);
        chk("pre_reset_count", 64'(fifo_count), 64'd2);
        local_coinc = 24'h000001;
        tick();
        chk("pre_reset_busy", 64'(busy), 64'd1);
        reset_n = 1'b0;
        local_coinc = 24'd0;
        tick();
        chk("midreset_valid", 64'(rec_valid), 64'd0);
        chk("midreset_count", 64'(fifo_count), 64'd0);
        chk("midreset_overflow", 64'(overflow_count), 64'd0);
        chk("midreset_busy", 64'(busy), 64'd0);
        reset_n = 1'b1;
        tick();
        tick();
        chk("post_reset_count", 64'(fifo_count), 64'd0);

        // enable low blocks new events but not an open one.
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            local_coinc = 24'h000007;
            tick();
        end
        local_coinc = 24'd0;
        tick();
        tick();
        chk("disabled_no_record", 64'(fifo_count), 64'd0);
        chk("disabled_busy", 64'(busy), 64'd0);
        enable = 1'b1;
        exp_q.push_back('{ts: timestamp, mask: 24'h000006, len: 16'd2, trunc: 1'b0, peak: 8'd1});
        local_coinc = 24'h000002;
        tick();
        enable = 1'b0;
        local_coinc = 24'h000004;
        tick();
        local_coinc = 24'd0;
        tick();
        tick();
        chk("enable_drop_record", 64'(fifo_count), 64'd1);
        enable = 1'b1;
        rec_ready = 1'b1;
        drain();

        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lc_event_recorder.md
Name: lc_event_recorder

Overview:
Consumer of the per-channel local-coincidence vector produced by the LC former.
- Detects each contiguous LC burst and accumulates the channel mask and duration.
- Timestamps the burst and pushes one record per burst into an internal FIFO.
- Presents records on a valid/ready interface to the readout/event builder.

Parameters:
N_CHANNELS, 24, width of local_coinc vector and record mask (1..255)
TS_WIDTH, 48, width of timestamp input and record timestamp
FIFO_DEPTH_LOG2, 4, record FIFO depth = 2**FIFO_DEPTH_LOG2 entries

Ports:
clk  in  1  system clock
reset_n  in  1  reset; synchronous, active-low
enable  in  1  permits new events to open; does not abort an open event
timestamp  in  TS_WIDTH  free-running time counter, sampled at event start
local_coinc  in  N_CHANNELS  per-channel LC flags from the LC former
max_event_len  in  16  event length limit in cycles; 0 = limit 65535
rec_valid  out  1  FIFO head holds a record
rec_ready  in  1  consumer accepts head when rec_valid & rec_ready
rec_ts  out  TS_WIDTH  timestamp of first nonzero local_coinc cycle
rec_mask  out  N_CHANNELS  OR of local_coinc over the event
rec_len  out  16  count of nonzero local_coinc cycles in the event
rec_trunc  out  1  event closed by the length limit
fifo_count  out  FIFO_DEPTH_LOG2+1  records currently held
overflow_count  out  16  records dropped on full FIFO; saturates at 0xFFFF
busy  out  1  state != IDLE

Behaviour:
- Reset (reset_n low at posedge): state IDLE, FIFO empty, rec_valid=0, all rec_* outputs 0, fifo_count=0, overflow_count=0, busy=0. Reset mid-event discards the event with no record.
- Let any = |local_coinc and lim = (max_event_len==0) ? 65535 : max_event_len.
- State IDLE:
  - If enable & any: capture ts=timestamp, mask=local_coinc, len=1, then go to OPEN.
  - If additionally lim==1: write the record immediately with trunc=1, then go to HOLDOFF.
- State OPEN, if any:
  - mask|=local_coinc, len+=1.
  - If the new len==lim: write the record with trunc=1, then go to HOLDOFF.
- State OPEN, if !any: write the record with trunc=0, then go to IDLE. At least one zero cycle separates two events.
- State HOLDOFF: stay until !any, then go to IDLE. Nonzero input in HOLDOFF is never recorded.
- enable low:
  - Blocks the IDLE->OPEN transition only.
  - An open event still closes normally.
- Record write ("push"):
  - Occurs on the clock edge that leaves OPEN (or IDLE when lim==1).
  - If the FIFO is full and no pop happens that cycle: record dropped and overflow_count += 1 (saturating).
  - Full with a simultaneous pop: push accepted and fifo_count unchanged.
- FIFO is first-word-fall-through:
  - rec_valid = (fifo_count != 0).
  - rec_* show the head entry and are stable while rec_valid & !rec_ready.
  - A pop occurs on the edge where rec_valid & rec_ready.
  - Push into an empty FIFO raises rec_valid on the following cycle (1-cycle latency from closing edge).
  - rec_ready while empty is ignored.
- Timing: burst of local_coinc nonzero for cycles S..S+L-1, zero at S+L, L < lim.
  - Push happens at the S+L edge; rec_valid is visible in cycle S+L+1.
  - Record contents: rec_ts = timestamp@S, rec_len = L.
- Widths:
  - len is 16-bit and cannot exceed lim, so it never wraps.
  - Record width = TS_WIDTH + N_CHANNELS + 17 (+8 with the optional feature).
  - FIFO pointers wrap modulo depth; fifo_count ranges 0..2**FIFO_DEPTH_LOG2.

Optional Feature:
Macro LC_EVENT_PEAK_EN.
- Defined:
  - Adds output rec_peak (8 bits) = maximum popcount of local_coinc over any single cycle of the event.
  - The popcount is computed combinationally and registered into the running maximum each OPEN cycle (IDLE start cycle included).
  - The value is stored in the FIFO alongside the record.
- Undefined: rec_peak port and its FIFO field are absent; no popcount logic is built.

Test Plan:
- Single burst: local_coinc=0x000003 for 3 cycles starting at timestamp 100, max_event_len=0 -> one record with ts=100, mask=0x000003, len=3, trunc=0; rec_valid rises 1 cycle after the closing edge.
- Mask accumulation: 0x000001, 0x000010, 0x000100 on consecutive cycles, then 0 -> mask=0x000111, len=3 (peak=1 with LC_EVENT_PEAK_EN); 0x000007 then 0x000003 -> peak=3.
- Truncation: max_event_len=4, local_coinc=0x800000 held 10 cycles -> one record with len=4, trunc=1; no second record until local_coinc returns to 0 and rises again.
- Overflow: FIFO_DEPTH_LOG2=2, rec_ready=0, 6 separated bursts -> fifo_count=4, overflow_count=2; then rec_ready=1 drains 4 records in push order with correct timestamps.
- Full with simultaneous pop: FIFO full, event closes on the same edge as a pop -> no drop, fifo_count stays 4, overflow_count unchanged.
- Control/reset: enable=0 during a burst -> no record; enable dropped mid-event -> the event still records; reset_n=0 mid-event and with 2 queued records -> rec_valid=0, fifo_count=0, overflow_count=0 next cycle.
